// File: rtl/n64adv_pkg.sv
// ============================================================================
// n64adv_pkg: shared widths, sync-nibble bit positions and helpers for the PPU.
// Revision: 1.0
// ============================================================================
`default_nettype none

package n64adv_pkg;

  localparam int color_width_i = 7;
  localparam int RGB_W         = 3 * color_width_i;

  localparam int VSYNC = 3;
  localparam int BLANK = 2;
  localparam int HSYNC = 1;
  localparam int CSYNC = 0;

  typedef logic [RGB_W-1:0] rgb_t;
  typedef logic [3:0]       sync_t;

  // All sync lines inactive, so the first real nibble cannot fake an edge.
  localparam sync_t SYNC_IDLE = 4'hF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/n64_pixel_capture.sv
// ============================================================================
// n64_pixel_capture: demultiplexes the 4-phase VI bus into sync/RGB, pixel and
// sync-edge strobes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module n64_pixel_capture
  import n64adv_pkg::*;
(
  input  logic                     vclk,
  input  logic                     rst,
  input  logic                     nvdsync,
  input  logic [color_width_i-1:0] vd,
  output rgb_t                     rgb,
  output logic                     pixel_active,
  output logic                     pixel_done,
  output logic                     line_start,
  output logic                     frame_start
);

  logic [1:0]               phase_q, phase_d;
  sync_t                    sync_q, sync_d;
  sync_t                    sync_prev_q, sync_prev_d;
  logic                     sync_new_q, sync_new_d;
  logic [color_width_i-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic                     pixel_done_q, pixel_done_d;

  always_comb begin
    phase_d      = phase_q;
    sync_d       = sync_q;
    sync_prev_d  = sync_prev_q;
    sync_new_d   = 1'b0;
    r_d          = r_q;
    g_d          = g_q;
    b_d          = b_q;
    pixel_done_d = 1'b0;
    if (!nvdsync) begin
      // A sync phase always restarts the pixel, dropping any partial one.
      phase_d     = 2'd0;
      sync_d      = vd[3:0];
      sync_prev_d = sync_q;
      sync_new_d  = 1'b1;
    end else begin
      case (phase_q)
        2'd0: begin
          r_d     = vd;
          phase_d = 2'd1;
        end
        2'd1: begin
          g_d     = vd;
          phase_d = 2'd2;
        end
        2'd2: begin
          b_d          = vd;
          phase_d      = 2'd3;
          pixel_done_d = 1'b1;
        end
        default: phase_d = 2'd3;
      endcase
    end
  end

  always_ff @(posedge vclk) begin
    if (rst) begin
      phase_q      <= 2'd0;
      sync_q       <= SYNC_IDLE;
      sync_prev_q  <= SYNC_IDLE;
      sync_new_q   <= 1'b0;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      pixel_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      sync_q       <= sync_d;
      sync_prev_q  <= sync_prev_d;
      sync_new_q   <= sync_new_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
      pixel_done_q <= pixel_done_d;
    end
  end

  assign rgb          = {r_q, g_q, b_q};
  assign pixel_active = sync_q[BLANK] & sync_q[CSYNC];
  assign pixel_done   = pixel_done_q;
  assign line_start   = sync_new_q & sync_prev_q[HSYNC] & ~sync_q[HSYNC];
  assign frame_start  = sync_new_q & sync_prev_q[VSYNC] & ~sync_q[VSYNC];

endmodule

`default_nettype wire

// File: rtl/n64_deblur_detect.sv
// ============================================================================
// n64_deblur_detect: classifies frames as pixel-doubled 320-wide content and
// produces the frame-synchronous ndo_deblur flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module n64_deblur_detect
  import n64adv_pkg::*;
#(
  parameter int unsigned BOUNDARY_MIN = 16,
  parameter int unsigned VOTE_FRAMES  = 4
) (
  input  logic                     VCLK,
  input  logic                     RST,
  input  logic                     nVDSYNC,
  input  logic [color_width_i-1:0] VD_i,
  input  logic                     n64_480i,
  input  logic                     nforcedeblur,
  input  logic                     ndeblurman,
  output logic                     ndo_deblur
);

  localparam int             VW       = $clog2(VOTE_FRAMES + 1);
  localparam logic [VW-1:0]  VOTE_MAX = VW'(VOTE_FRAMES);
  localparam logic [7:0]     BND_MIN  = 8'(BOUNDARY_MIN);

  rgb_t rgb;
  logic pixel_active, pixel_done, line_start, frame_start;

  n64_pixel_capture u_capture (
    .vclk         (VCLK),
    .rst          (RST),
    .nvdsync      (nVDSYNC),
    .vd           (VD_i),
    .rgb          (rgb),
    .pixel_active (pixel_active),
    .pixel_done   (pixel_done),
    .line_start   (line_start),
    .frame_start  (frame_start)
  );

  logic          parity_q, parity_d;
  logic          have_prev_q, have_prev_d;
  rgb_t          prev_rgb_q, prev_rgb_d;
  logic [7:0]    pair_diff_q, pair_diff_d;
  logic [7:0]    bnd_diff_q, bnd_diff_d;
  logic [VW-1:0] vote_q, vote_d;
  logic          ndo_q, ndo_d;
  logic          deblur_auto;

  always_comb begin
    parity_d    = parity_q;
    have_prev_d = have_prev_q;
    prev_rgb_d  = prev_rgb_q;
    pair_diff_d = pair_diff_q;
    bnd_diff_d  = bnd_diff_q;
    vote_d      = vote_q;
    ndo_d       = ndo_q;
    deblur_auto = 1'b0;

    if (frame_start) begin
      if (pair_diff_q != 8'd0) begin
        vote_d = '0;
      end else if (bnd_diff_q >= BND_MIN) begin
        vote_d = (vote_q == VOTE_MAX) ? vote_q : vote_q + VW'(1);
      end
      deblur_auto = (vote_d == VOTE_MAX);
      if (n64_480i)           ndo_d = 1'b1;
      else if (!nforcedeblur) ndo_d = 1'b0;
      else if (!ndeblurman)   ndo_d = 1'b1;
      else                    ndo_d = ~deblur_auto;
      pair_diff_d = 8'd0;
      bnd_diff_d  = 8'd0;
    end

    if (line_start) begin
      parity_d    = 1'b0;
      have_prev_d = 1'b0;
    end

    // Counting starts from the (possibly just cleared) values so a pixel
    // landing on frame_start is attributed to the new frame.
    if (pixel_done && pixel_active) begin
      if (have_prev_d && (rgb != prev_rgb_q)) begin
        if (parity_d) pair_diff_d = sat_inc8(pair_diff_d);
        else          bnd_diff_d  = sat_inc8(bnd_diff_d);
      end
      prev_rgb_d  = rgb;
      have_prev_d = 1'b1;
      parity_d    = ~parity_d;
    end
  end

  always_ff @(posedge VCLK) begin
    if (RST) begin
      parity_q    <= 1'b0;
      have_prev_q <= 1'b0;
      prev_rgb_q  <= '0;
      pair_diff_q <= 8'd0;
      bnd_diff_q  <= 8'd0;
      vote_q      <= '0;
      ndo_q       <= 1'b1;
    end else begin
      parity_q    <= parity_d;
      have_prev_q <= have_prev_d;
      prev_rgb_q  <= prev_rgb_d;
      pair_diff_q <= pair_diff_d;
      bnd_diff_q  <= bnd_diff_d;
      vote_q      <= vote_d;
      ndo_q       <= ndo_d;
    end
  end

  assign ndo_deblur = ndo_q;

endmodule

`default_nettype wire

// File: tb/tb_n64_deblur_detect.sv
// ============================================================================
// tb_n64_deblur_detect: frame-level vectors for the deblur detector.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_n64_deblur_detect;

  localparam int K_BLUR = 0;
  localparam int K_FLAT = 1;
  localparam int K_ODD  = 2;

  typedef struct {
    int kind;
    int npairs;
    int nlines;
    bit n480i;
    bit nforce;
    bit nman;
    bit exp_ndo;
  } vec_t;

  logic       VCLK = 1'b0;
  logic       RST = 1'b1;
  logic       nVDSYNC = 1'b1;
  logic [6:0] VD_i = 7'd0;
  logic       n64_480i = 1'b0;
  logic       nforcedeblur = 1'b1;
  logic       ndeblurman = 1'b1;
  logic       ndo_deblur;

  int   checks = 0;
  int   failures = 0;
  bit   exp_q[$];
  vec_t vecs[$];

  n64_deblur_detect #(.BOUNDARY_MIN(16), .VOTE_FRAMES(4)) dut (
    .VCLK         (VCLK),
    .RST          (RST),
    .nVDSYNC      (nVDSYNC),
    .VD_i         (VD_i),
    .n64_480i     (n64_480i),
    .nforcedeblur (nforcedeblur),
    .ndeblurman   (ndeblurman),
    .ndo_deblur   (ndo_deblur)
  );

  always #5 VCLK = ~VCLK;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: ndo_deblur=%b expected %b", name, act, exp);
    end
  endtask

  task automatic cyc(input logic nvd, input logic [6:0] vd);
    @(negedge VCLK);
    nVDSYNC = nvd;
    VD_i    = vd;
  endtask

  // trunc: drop the B phase so the next sync arrives at phase 2
  task automatic pixel(input logic [3:0] s, input logic [20:0] v, input bit trunc);
    cyc(1'b0, {3'b000, s});
    cyc(1'b1, v[20:14]);
    cyc(1'b1, v[13:7]);
    if (!trunc) cyc(1'b1, v[6:0]);
  endtask

  function automatic logic [20:0] pix_val(input int kind, input int l, input int j);
    logic [20:0] v;
    int k;
    k = j / 2;
    if (kind == K_FLAT) v = 21'h0AB5C3;
    else                v = {7'(k + 1), 7'(l + 3), 7'(k * 5 + l)};
    if (kind == K_ODD && l == 0 && j == 1) v = v ^ 21'h1;
    return v;
  endfunction

  task automatic send_lines(input int kind, input int npairs, input int nlines, input bit trunc);
    for (int l = 0; l < nlines; l++) begin
      pixel(4'b1000, 21'h0, 1'b0);
      for (int j = 0; j < 2 * npairs; j++) begin
        if (trunc && j == 3) pixel(4'hF, 21'h1FFFFF, 1'b1);
        pixel(4'hF, pix_val(kind, l, j), 1'b0);
      end
    end
  endtask

  // Sends the vsync pixel, then compares against the oldest pending expectation.
  task automatic frame_edge(input string name);
    pixel(4'b0010, 21'h0, 1'b0);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: no expected value queued", name);
    end else begin
      check(name, ndo_deblur, exp_q.pop_front());
    end
  endtask

  function automatic void add(input int kind, input int np, input int nl,
                              input bit i480, input bit nf, input bit nm, input bit e);
    vec_t v;
    v = '{kind: kind, npairs: np, nlines: nl, n480i: i480, nforce: nf, nman: nm, exp_ndo: e};
    vecs.push_back(v);
  endfunction

  initial begin
    // Blurred frames build votes 1..4, saturate, then an odd mismatch resets.
    add(K_BLUR, 20, 2, 0, 1, 1, 1);
    add(K_BLUR, 20, 2, 0, 1, 1, 1);
    add(K_BLUR, 20, 2, 0, 1, 1, 1);
    add(K_BLUR, 20, 2, 0, 1, 1, 0);
    add(K_BLUR, 20, 2, 0, 1, 1, 0);
    add(K_ODD,  20, 2, 0, 1, 1, 1);
    add(K_BLUR, 20, 2, 0, 1, 1, 1);
    add(K_BLUR, 20, 2, 0, 1, 1, 1);
    add(K_BLUR, 20, 2, 0, 1, 1, 1);
    add(K_BLUR, 20, 2, 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) add(K_FLAT, 20, 1, 0, 1, 1, 0);
    add(K_ODD,  20, 1, 0, 1, 1, 1);
    // 15 boundaries: no vote; 16 boundaries: YES vote
    for (int i = 0; i < 4; i++) add(K_BLUR, 16, 1, 0, 1, 1, 1);
    add(K_BLUR, 17, 1, 0, 1, 1, 1);
    add(K_BLUR, 17, 1, 0, 1, 1, 1);
    add(K_BLUR, 17, 1, 0, 1, 1, 1);
    add(K_BLUR, 17, 1, 0, 1, 1, 0);
    // Configuration priority
    add(K_ODD,  20, 1, 1, 0, 1, 1);
    add(K_BLUR, 20, 2, 0, 0, 1, 0);
    add(K_BLUR, 20, 2, 0, 1, 1, 1);
    add(K_BLUR, 20, 2, 0, 1, 0, 1);
    add(K_BLUR, 20, 2, 1, 0, 1, 1);
    add(K_BLUR, 20, 2, 0, 0, 1, 0);
    add(K_BLUR, 20, 1, 0, 1, 0, 1);

    repeat (3) @(negedge VCLK);
    check("reset_state", ndo_deblur, 1'b1);
    RST = 1'b0;

    exp_q.push_back(1'b1);
    frame_edge("first_frame_start");

    for (int i = 0; i < vecs.size(); i++) begin
      n64_480i     = vecs[i].n480i;
      nforcedeblur = vecs[i].nforce;
      ndeblurman   = vecs[i].nman;
      exp_q.push_back(vecs[i].exp_ndo);
      send_lines(vecs[i].kind, vecs[i].npairs, vecs[i].nlines, 1'b0);
      frame_edge($sformatf("row%0d", i));
    end

    // Mid-frame config change only lands at the following frame_start.
    n64_480i = 1'b0; nforcedeblur = 1'b1; ndeblurman = 1'b0;
    exp_q.push_back(1'b0);
    send_lines(K_BLUR, 20, 1, 1'b0);
    check("midframe_hold_a", ndo_deblur, 1'b1);
    nforcedeblur = 1'b0;
    send_lines(K_BLUR, 20, 1, 1'b0);
    check("midframe_hold_b", ndo_deblur, 1'b1);
    frame_edge("cfg_at_frame_start");

    // Reset mid-frame from the deblurred state.
    nforcedeblur = 1'b1; ndeblurman = 1'b1;
    exp_q.push_back(1'b0);
    send_lines(K_BLUR, 20, 1, 1'b0);
    frame_edge("pre_reset_deblurred");
    send_lines(K_BLUR, 5, 1, 1'b0);
    cyc(1'b0, 7'h0F);
    cyc(1'b1, 7'h11);
    @(negedge VCLK);
    RST = 1'b1;
    nVDSYNC = 1'b1;
    @(negedge VCLK);
    check("reset_midframe", ndo_deblur, 1'b1);
    RST = 1'b0;
    exp_q.push_back(1'b1);
    frame_edge("post_reset_empty");
    for (int f = 0; f < 4; f++) begin
      exp_q.push_back(f == 3 ? 1'b0 : 1'b1);
      send_lines(K_BLUR, 20, 1, 1'b1);
      frame_edge($sformatf("post_reset_vote%0d", f + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/n64_deblur_detect.md
Name: n64_deblur_detect

Overview:
Detects whether the N64 VI is outputting horizontally "blurred" 320-pixel content, where every pixel pair on the 640-wide bus carries identical data. It watches the multiplexed video bus, classifies each frame by comparing neighbouring pixels, and applies frame-level hysteresis. It combines that automatic decision with user configuration into a single registered ndo_deblur flag. The flag is consumed by the demux and output stages of the PPU.

Parameters:
color_width_i, 7, bits per colour component on VD_i.
BOUNDARY_MIN, 16, minimum pair-boundary differences per frame for a "blurred" vote.
VOTE_FRAMES, 4, consecutive "blurred" votes needed before auto-deblur asserts.

Ports:
VCLK  in  1  video clock; all logic is on its rising edge.
RST  in  1  synchronous reset, active-high.
nVDSYNC  in  1  low for exactly one cycle per pixel, the sync phase.
VD_i  in  color_width_i  multiplexed bus. Sync phase: bit3 nVSYNC, bit2 nBLANK (high = active video), bit1 nHSYNC, bit0 nCSYNC. Phases 1, 2 and 3 carry R, G and B.
n64_480i  in  1  interlaced-mode flag from vinfo.
nforcedeblur  in  1  0 = force deblur on.
ndeblurman  in  1  0 = manual mode, deblur off.
ndo_deblur  out  1  0 = deblur active; registered.

Behaviour:
- Phase counter (2 bit):
  - Loads 0 on any cycle with nVDSYNC=0 and increments otherwise, saturating at 3.
  - Sync nibble is latched at phase 0; R, G and B are latched at phases 1, 2 and 3.
  - pixel_done pulses on the cycle after B is latched.
  - If nVDSYNC goes low early, a partial pixel is discarded with no pixel_done.
- Edge detection on latched sync bits, versus the previous latched nibble:
  - line_start = nHSYNC 1->0.
  - frame_start = nVSYNC 1->0.
- Pixel parity:
  - A pixel is active when latched nBLANK=1 and nCSYNC=1.
  - Parity clears at line_start and toggles on each active pixel_done.
  - Parity 0 = even (first pixel of the line).
- Per active pixel_done, compare the 21-bit RGB with the previous active pixel on the same line. The first pixel of a line is never compared.
  - Odd pixel differing from previous: pair_diff +1.
  - Even pixel differing from previous: boundary_diff +1.
  - Both counters are 8-bit and saturate at 255.
- At frame_start, evaluate the finished frame, then clear both counters in the same cycle. A pixel_done coinciding with frame_start is counted into the new frame.
  - pair_diff>0: vote NO, and vote_cnt clears to 0.
  - pair_diff==0 and boundary_diff>=BOUNDARY_MIN: vote YES, and vote_cnt increments, saturating at VOTE_FRAMES.
  - Otherwise no vote, and vote_cnt holds.
  - deblur_auto = (vote_cnt==VOTE_FRAMES).
- Output, updated only at frame_start so it never switches mid-frame, in priority order:
  1. n64_480i=1 -> 1.
  2. nforcedeblur=0 -> 0.
  3. ndeblurman=0 -> 1.
  4. Otherwise -> ~deblur_auto, using the value computed from this evaluation.
- Config and 480i changes take effect at the next frame_start. The heuristic keeps running while 480i is set.
- Reset state: ndo_deblur=1, counters 0, vote_cnt 0, parity 0, phase 0, latched sync = 4'hF (no false edge after reset). Reset mid-frame discards all evidence.

Decomposition:
- Shared package n64adv_pkg: color_width_i and the sync bit indices VSYNC=3, BLANK=2, HSYNC=1, CSYNC=0.
- Sub-module n64_pixel_capture holds the phase counter, RGB/sync latches, pixel_done, line_start and frame_start.
- The top level holds the comparator, counters, vote FSM and output mux.

Test Plan:
1. Auto mode, 240p, lines of pixel pairs (a,a,b,b,...) with 20 distinct pairs per line, for 4 frames. ndo_deblur=1 through the 4th frame_start, then 0 from the 5th frame_start onwards.
2. Deblurred state established, then one frame with a single odd pixel differing from its partner. At the next frame_start: vote_cnt=0 and ndo_deblur=1.
3. Uniform flat frames (boundary_diff=0). vote_cnt holds and the output is unchanged across 10 frames.
4. n64_480i=1 with blurred content, and nforcedeblur=0. ndo_deblur=1. After n64_480i goes to 0, ndo_deblur=0 at the next frame_start.
5. Manual mode: ndeblurman=0 with blurred content gives ndo_deblur=1. Changing to nforcedeblur=0 mid-frame leaves the output unchanged until frame_start, where it drops to 0.
6. Assert RST mid-frame. ndo_deblur=1 in the next cycle, and the first frame after release needs VOTE_FRAMES fresh YES votes; a truncated pixel (nVDSYNC low at phase 2) gives no pixel_done.
